// File: rtl/riscv_pc_unit.sv
// Program-counter unit for the RV32I fetch stage: next-PC selection, stall,
// misaligned-target trapping with fault capture, and a circular return-address stack.
module riscv_pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcEn,
  input  logic [1:0]      pcSrc,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] target,
  input  logic            rasPush,
  input  logic            rasPop,
  output logic [XLEN-1:0] pcOutput,
  output logic [XLEN-1:0] pcPlus4,
  output logic [XLEN-1:0] rasTop,
  output logic            rasValid,
  output logic            misaligned,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] badAddr
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_TRAP   = 2'b11;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
  logic             misaligned_q, misaligned_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  cand_c;
  logic             misalign_c;
  logic [PTR_W-1:0] top_inc_c;

  assign pcOutput   = pc_q;
  assign pcPlus4    = pc_q + XLEN'(4);
  assign rasValid   = (cnt_q != '0);
  assign rasTop     = rasValid ? ras_q[top_q] : '0;
  assign misaligned = misaligned_q;
  assign epc        = epc_q;
  assign badAddr    = bad_addr_q;
  assign top_inc_c  = top_q + PTR_W'(1);

  // Candidate next PC; only branch and jump targets can carry misaligned low bits.
  always_comb begin
    cand_c = pcPlus4;
    unique case (pcSrc)
      SRC_SEQ:    cand_c = pcPlus4;
      SRC_BRANCH: cand_c = pc_q + offset;
      SRC_JUMP:   cand_c = {target[XLEN-1:1], 1'b0};
      SRC_TRAP:   cand_c = TRAP_VECTOR;
      default:    cand_c = pcPlus4;
    endcase
    misalign_c = ((pcSrc == SRC_BRANCH) || (pcSrc == SRC_JUMP)) && (cand_c[1:0] != 2'b00);
  end

  // Next-state: PC redirect, fault capture and RAS update, all frozen on stall.
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    bad_addr_d   = bad_addr_q;
    misaligned_d = 1'b0;
    ras_d        = ras_q;
    top_d        = top_q;
    cnt_d        = cnt_q;
    if (pcEn) begin
      if (pcSrc == SRC_TRAP) begin
        pc_d  = TRAP_VECTOR;
        epc_d = pc_q;
      end else if (misalign_c) begin
        pc_d         = TRAP_VECTOR;
        epc_d        = pc_q;
        bad_addr_d   = cand_c;
        misaligned_d = 1'b1;
      end else begin
        pc_d = cand_c;
      end

      if (rasPush && (!rasPop || (cnt_q == '0))) begin
        top_d            = top_inc_c;
        ras_d[top_inc_c] = pcPlus4;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (rasPush) begin
        ras_d[top_q] = pcPlus4;
      end else if (rasPop && (cnt_q != '0)) begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      bad_addr_q   <= '0;
      misaligned_q <= 1'b0;
      top_q        <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      bad_addr_q   <= bad_addr_d;
      misaligned_q <= misaligned_d;
      top_q        <= top_d;
      cnt_q        <= cnt_d;
      ras_q        <= ras_d;
    end
  end

endmodule

// File: tb/tb_riscv_pc_unit.sv
// Self-checking bench for riscv_pc_unit: directed test-plan sequences with literal
// expectations, then randomized traffic checked each cycle against a queue-based model.
module tb_riscv_pc_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst, pcEn, rasPush, rasPop;
  logic [1:0]  pcSrc;
  logic [31:0] offset, target;
  logic [31:0] pcOutput, pcPlus4, rasTop, epc, badAddr;
  logic        rasValid, misaligned;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_epc, m_bad;
  logic        m_mis;
  logic [31:0] m_ras[$];

  riscv_pc_unit #(
    .XLEN(32), .RESET_VECTOR(RESET_VEC), .TRAP_VECTOR(TRAP_VEC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pcEn(pcEn), .pcSrc(pcSrc), .offset(offset), .target(target),
    .rasPush(rasPush), .rasPop(rasPop), .pcOutput(pcOutput), .pcPlus4(pcPlus4),
    .rasTop(rasTop), .rasValid(rasValid), .misaligned(misaligned), .epc(epc), .badAddr(badAddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: RAS is a queue whose back is the top; oldest entry falls off the front.
  always @(posedge clk) begin
    logic [31:0] cand, old_pc, p4;
    if (rst) begin
      m_pc = RESET_VEC; m_epc = 0; m_bad = 0; m_mis = 0;
      m_ras.delete();
    end else if (!pcEn) begin
      m_mis = 0;
    end else begin
      old_pc = m_pc;
      p4     = old_pc + 32'd4;
      case (pcSrc)
        2'd0:    cand = p4;
        2'd1:    cand = old_pc + offset;
        2'd2:    cand = target & ~32'd1;
        default: cand = TRAP_VEC;
      endcase
      m_mis = 0;
      if (pcSrc == 2'd3) begin
        m_pc = TRAP_VEC; m_epc = old_pc;
      end else if (cand % 4 != 0) begin
        m_pc = TRAP_VEC; m_epc = old_pc; m_bad = cand; m_mis = 1;
      end else begin
        m_pc = cand;
      end
      if (rasPush && rasPop && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = p4;
      end else if (rasPush) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (rasPop && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pcOutput", pcOutput, m_pc);
      chk("pcPlus4", pcPlus4, m_pc + 32'd4);
      chk("rasValid", 32'(rasValid), 32'(m_ras.size() > 0));
      chk("rasTop", rasTop, (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0);
      chk("misaligned", 32'(misaligned), 32'(m_mis));
      chk("epc", epc, m_epc);
      chk("badAddr", badAddr, m_bad);
    end
  end

  task automatic step(input logic en, input logic [1:0] src, input logic [31:0] off,
                      input logic [31:0] tgt, input logic push, input logic pop);
    pcEn = en; pcSrc = src; offset = off; target = tgt; rasPush = push; rasPop = pop;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pop_exp [4];
    pop_exp[0] = 32'h14; pop_exp[1] = 32'h10; pop_exp[2] = 32'h0C; pop_exp[3] = 32'h08;

    rst = 1'b1;
    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("lit_reset_pc", pcOutput, 32'h0);
    chk("lit_reset_pc4", pcPlus4, 32'h4);
    chk("lit_reset_rasValid", 32'(rasValid), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("lit_seq_pc", pcOutput, 32'h18);
    chk("lit_seq_pc4", pcPlus4, 32'h1C);
    step(1'b1, 2'd1, 32'd32, 32'd0, 1'b0, 1'b0);
    chk("lit_branch_fwd", pcOutput, 32'h38);
    step(1'b1, 2'd1, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0);
    chk("lit_branch_back", pcOutput, 32'h30);

    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 32'd100, 32'd0, 1'b1, 1'b0);
    chk("lit_stall_pc", pcOutput, 32'h30);
    chk("lit_stall_rasValid", 32'(rasValid), 32'h0);
    step(1'b1, 2'd1, 32'd16, 32'd0, 1'b0, 1'b0);
    chk("lit_resume_pc", pcOutput, 32'h40);

    step(1'b1, 2'd2, 32'd0, 32'h203, 1'b0, 1'b0);
    chk("lit_jmis_pc", pcOutput, 32'h100);
    chk("lit_jmis_epc", epc, 32'h40);
    chk("lit_jmis_bad", badAddr, 32'h202);
    chk("lit_jmis_flag", 32'(misaligned), 32'h1);
    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("lit_jmis_pulse_end", 32'(misaligned), 32'h0);
    chk("lit_jmis_bad_hold", badAddr, 32'h202);

    step(1'b1, 2'd2, 32'd0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0);
    chk("lit_wrap", pcOutput, 32'hFFFF_FFFC);
    step(1'b1, 2'd2, 32'd0, 32'h10, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'd6, 32'd0, 1'b0, 1'b0);
    chk("lit_bmis_bad", badAddr, 32'h16);
    chk("lit_bmis_epc", epc, 32'h10);
    step(1'b1, 2'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("lit_trap_flag", 32'(misaligned), 32'h0);
    chk("lit_trap_bad_hold", badAddr, 32'h16);

    rst = 1'b1;
    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("lit_ras_pop_top", rasTop, pop_exp[i]);
      step(1'b1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    end
    chk("lit_ras_empty", 32'(rasValid), 32'h0);
    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("lit_ras_pop_empty", rasTop, 32'h0);
    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lit_ras_push", rasTop, 32'h2C);
    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("lit_ras_replace", rasTop, 32'h30);
    chk("lit_ras_replace_valid", 32'(rasValid), 32'h1);

    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 2'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    chk("lit_pre_rst_mis", 32'(misaligned), 32'h1);
    rst = 1'b1;
    step(1'b1, 2'd1, 32'd2, 32'd0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("lit_rst_pc", pcOutput, 32'h0);
    chk("lit_rst_rasValid", 32'(rasValid), 32'h0);
    chk("lit_rst_rasTop", rasTop, 32'h0);
    chk("lit_rst_mis", 32'(misaligned), 32'h0);
    chk("lit_rst_epc", epc, 32'h0);
    chk("lit_rst_bad", badAddr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] off, tgt;
      off = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 255)) - 128);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), off, tgt,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
